lwdf_sample_tx: RTL

Transmit side of the chip's sample I/O. It takes parallel filter-output samples from the LWDF datapath and buffers them in a small FIFO. It then sends each sample byte-serially on the dedicated output pins using a 4-phase req/ack handshake, with the external host (bench or board MCU) as the receiver. It sits between the filter core and the top-level pin mux: out_byte drives uo_out, and out_req/out_ack map onto uio pins.

---
 rtl/lwdf_pkg.sv | 21 ++
 rtl/lwdf_sample_tx_if.sv | 32 +++
 rtl/lwdf_sync2.sv | 21 ++
 rtl/lwdf_sample_tx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/lwdf_pkg.sv
// Shared definitions for the LWDF sample I/O blocks.
//   LWDF_SAMPLE_W : default sample width, shared with the filter core
//   tx_state_e    : transmit FSM states
//   bytes_of()    : number of bytes in a sample of a given width
package lwdf_pkg;

    localparam int LWDF_SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETUP  = 3'd2,
        REQ_HI = 3'd3,
        REQ_LO = 3'd4
    } tx_state_e;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/lwdf_sample_tx_if.sv
// Bus bundle between the filter core, lwdf_sample_tx and the host pins.
//   in_data/in_valid/in_ready : sample stream from the filter core. A sample
//       moves on a rising clk edge when in_valid && in_ready; in_ready does
//       not depend on in_valid.
//   out_byte/out_last/out_req/out_ack : 4-phase byte link to the host.
//       out_byte/out_last are set up before out_req rises and held until the
//       host has raised and then dropped out_ack; out_req rises, the host
//       answers with out_ack=1, out_req falls, the host answers out_ack=0.
// Modports: master = transmitter (lwdf_sample_tx), slave = its environment.
interface lwdf_sample_tx_if
    import lwdf_pkg::*;
#(
    parameter int DATA_W = LWDF_SAMPLE_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_byte;
    logic              out_req;
    logic              out_ack;
    logic              out_last;

    modport master (
        input  in_data, in_valid, out_ack,
        output in_ready, out_byte, out_req, out_last
    );

    modport slave (
        output in_data, in_valid, out_ack,
        input  in_ready, out_byte, out_req, out_last
    );
endinterface

// File: rtl/lwdf_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst (synchronous, active-high, clears to 0), d (async in),
//        q (synchronised out, two clk cycles of latency).
module lwdf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/lwdf_sample_tx.sv
// Transmit side of the sample I/O: buffers filter samples in a small FIFO
// and sends each one LSB byte first over a 4-phase req/ack link.
// Ports: clk, rst (synchronous, active-high)
//        bus      : lwdf_sample_tx_if.master (sample stream + host link)
//        overflow : sticky, set when a sample is offered while the FIFO is full
//        state    : current FSM state (debug observation)
//        out_par  : even parity of out_byte, only when LWDF_TX_PARITY_EN is defined
// Parameters: DATA_W (multiple of 8), FIFO_DEPTH (power of 2, >= 2)
module lwdf_sample_tx
    import lwdf_pkg::*;
#(
    parameter int DATA_W     = LWDF_SAMPLE_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    lwdf_sample_tx_if.master         bus,
    output logic                     overflow,
    output tx_state_e                state
`ifdef LWDF_TX_PARITY_EN
    ,
    output logic                     out_par
`endif
);
    localparam int BYTES = bytes_of(DATA_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    // ---------------- sample FIFO ----------------
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign push  = bus.in_valid && !full;  // a pop in the same cycle never frees space for it
    assign pop   = (state == LOAD);        // LOAD is only entered with the FIFO non-empty

    assign bus.in_ready = !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= bus.in_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (bus.in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- ack synchroniser ----------------
    logic ack_s;

    lwdf_sync2 u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.out_ack),
        .q   (ack_s)
    );

    // ---------------- transmit FSM ----------------
    // out_byte/out_last are loaded on the edge that enters SETUP, so they are
    // already valid during SETUP and stay put until REQ_LO completes.
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    assign shift_nxt = shreg >> 8;
    assign idx_nxt   = idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            idx          <= '0;
            bus.out_byte <= '0;
            bus.out_last <= 1'b0;
            bus.out_req  <= 1'b0;
`ifdef LWDF_TX_PARITY_EN
            out_par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) state <= LOAD;
                end
                LOAD: begin
                    shreg        <= head;
                    idx          <= '0;
                    bus.out_byte <= head[7:0];
                    bus.out_last <= (BYTES == 1);
`ifdef LWDF_TX_PARITY_EN
                    out_par      <= ^head[7:0];
`endif
                    state        <= SETUP;
                end
                SETUP: begin
                    bus.out_req <= 1'b1;
                    state       <= REQ_HI;
                end
                REQ_HI: begin
                    if (ack_s) begin
                        bus.out_req <= 1'b0;
                        state       <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        if (idx == LAST_IDX) begin
                            state <= empty ? IDLE : LOAD;
                        end else begin
                            shreg        <= shift_nxt;
                            idx          <= idx_nxt;
                            bus.out_byte <= shift_nxt[7:0];
                            bus.out_last <= (idx_nxt == LAST_IDX);
`ifdef LWDF_TX_PARITY_EN
                            out_par      <= ^shift_nxt[7:0];
`endif
                            state        <= SETUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
